// File: rtl/ex_mem_execute_stage.sv
// Execute stage: operand forwarding, ALU, iterative signed multiplier (HI/LO) and EX/MEM register.
// Optional build macro EX_FORWARD_EN enables the EX/MEM and MEM/WB forwarding muxes.

module ex_mem_execute_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,

    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] reg_file_out_1_in,
    input  logic [31:0] reg_file_out_2_in,
    input  logic [31:0] sign_extended_in,
    input  logic [4:0]  reg_rs_address_in,
    input  logic [4:0]  reg_rt_address_in,
    input  logic [4:0]  reg_rd_address_in,
    input  logic [1:0]  register_destination_in,
    input  logic [1:0]  alu_op_in,
    input  logic        memory_read_in,
    input  logic        memory_write_in,
    input  logic        memory_to_register_in,
    input  logic        alu_source_in,
    input  logic        reg_write_in,
    input  logic        memory_write_source_in,
    input  logic        memory_read_source_in,

    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_write_reg,
    input  logic [31:0] mem_wb_write_data,

    output logic        ex_stall,
    output logic [31:0] alu_result_out,
    output logic [31:0] write_data_out,
    output logic [4:0]  write_reg_out,
    output logic        memory_read_out,
    output logic        memory_write_out,
    output logic        memory_to_register_out,
    output logic        reg_write_out,
    output logic        memory_write_source_out,
    output logic        memory_read_source_out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_t;

    localparam logic [4:0] LAST_STEP = 5'(MUL_CYCLES - 1);

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] operand_b2;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] alu_value;
    logic [31:0] result_value;
    logic [4:0]  dest_reg;
    logic        is_mult;

    mult_state_t state;
    mult_state_t next_state;
    logic        start_mult;
    logic        finish_mult;
    logic [4:0]  counter;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic        product_negative;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

`ifdef EX_FORWARD_EN
    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    always_comb begin
        operand_a = reg_file_out_1_in;
        if (reg_write_out && (write_reg_out != 5'd0) && (write_reg_out == reg_rs_address_in))
            operand_a = alu_result_out;
        else if (mem_wb_reg_write && (mem_wb_write_reg != 5'd0) && (mem_wb_write_reg == reg_rs_address_in))
            operand_a = mem_wb_write_data;

        operand_b = reg_file_out_2_in;
        if (reg_write_out && (write_reg_out != 5'd0) && (write_reg_out == reg_rt_address_in))
            operand_b = alu_result_out;
        else if (mem_wb_reg_write && (mem_wb_write_reg != 5'd0) && (mem_wb_write_reg == reg_rt_address_in))
            operand_b = mem_wb_write_data;
    end
`else
    assign operand_a = reg_file_out_1_in;
    assign operand_b = reg_file_out_2_in;

    logic unused_forward_inputs;
    assign unused_forward_inputs = ^{mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
                                     reg_rs_address_in};
`endif

    assign operand_b2 = alu_source_in ? sign_extended_in : operand_b;
    assign funct      = sign_extended_in[5:0];
    assign shamt      = sign_extended_in[10:6];
    assign is_mult    = (alu_op_in == 2'b10) && (funct == FUNCT_MULT);

    always_comb begin
        alu_value = 32'd0;
        case (alu_op_in)
            2'b00: alu_value = operand_a + operand_b2;
            2'b01: alu_value = operand_a - operand_b2;
            2'b11: alu_value = operand_a | {16'b0, sign_extended_in[15:0]};
            default: begin
                case (funct)
                    FUNCT_ADD:  alu_value = operand_a + operand_b2;
                    FUNCT_SUB:  alu_value = operand_a - operand_b2;
                    FUNCT_AND:  alu_value = operand_a & operand_b2;
                    FUNCT_OR:   alu_value = operand_a | operand_b2;
                    FUNCT_SLT:  alu_value = {31'b0, $signed(operand_a) < $signed(operand_b2)};
                    FUNCT_SLL:  alu_value = operand_b2 << shamt;
                    FUNCT_SRL:  alu_value = operand_b2 >> shamt;
                    FUNCT_MFHI: alu_value = hi_reg;
                    FUNCT_MFLO: alu_value = lo_reg;
                    default:    alu_value = 32'd0;
                endcase
            end
        endcase
    end

    always_comb begin
        dest_reg     = reg_rt_address_in;
        result_value = alu_value;
        case (register_destination_in)
            2'b01: dest_reg = reg_rd_address_in;
            2'b10: begin
                dest_reg     = 5'd31;
                result_value = pc_plus_4_in;
            end
            default: dest_reg = reg_rt_address_in;
        endcase
    end

    // A flushed MULT no longer needs the pipeline held, even mid-iteration.
    assign ex_stall = rst_n && !flush && is_mult && (state != DONE);

    always_comb begin
        next_state  = state;
        start_mult  = 1'b0;
        finish_mult = 1'b0;
        case (state)
            IDLE: begin
                if (is_mult && !flush) begin
                    next_state = BUSY;
                    start_mult = 1'b1;
                end
            end
            BUSY: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (counter == LAST_STEP) begin
                    next_state  = DONE;
                    finish_mult = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Unsigned magnitudes; 0x80000000 negates to itself, which is the correct magnitude 2^31.
    assign abs_a    = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    assign abs_b    = operand_b[31] ? (32'd0 - operand_b) : operand_b;
    assign acc_next = acc + (mplier[0] ? mcand : 64'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter          <= 5'd0;
            mcand            <= 64'd0;
            mplier           <= 32'd0;
            acc              <= 64'd0;
            product_negative <= 1'b0;
            hi_reg           <= 32'd0;
            lo_reg           <= 32'd0;
        end else begin
            if (start_mult) begin
                counter          <= 5'd0;
                mcand            <= {32'd0, abs_a};
                mplier           <= abs_b;
                acc              <= 64'd0;
                product_negative <= operand_a[31] ^ operand_b[31];
            end else if ((state == BUSY) && !flush) begin
                counter <= counter + 5'd1;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                acc     <= acc_next;
            end
            if (finish_mult) begin
                {hi_reg, lo_reg} <= product_negative ? (64'd0 - acc_next) : acc_next;
            end
        end
    end

    // MULT never writes a GPR, so it retires as a bubble just like a flushed or stalled slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_out          <= 32'd0;
            write_data_out          <= 32'd0;
            write_reg_out           <= 5'd0;
            memory_read_out         <= 1'b0;
            memory_write_out        <= 1'b0;
            memory_to_register_out  <= 1'b0;
            reg_write_out           <= 1'b0;
            memory_write_source_out <= 1'b0;
            memory_read_source_out  <= 1'b0;
        end else if (flush || ex_stall || is_mult) begin
            alu_result_out          <= 32'd0;
            write_data_out          <= 32'd0;
            write_reg_out           <= 5'd0;
            memory_read_out         <= 1'b0;
            memory_write_out        <= 1'b0;
            memory_to_register_out  <= 1'b0;
            reg_write_out           <= 1'b0;
            memory_write_source_out <= 1'b0;
            memory_read_source_out  <= 1'b0;
        end else begin
            alu_result_out          <= result_value;
            write_data_out          <= operand_b;
            write_reg_out           <= dest_reg;
            memory_read_out         <= memory_read_in;
            memory_write_out        <= memory_write_in;
            memory_to_register_out  <= memory_to_register_in;
            reg_write_out           <= reg_write_in;
            memory_write_source_out <= memory_write_source_in;
            memory_read_source_out  <= memory_read_source_in;
        end
    end

endmodule

// File: tb/tb_ex_mem_execute_stage.sv
// Directed self-checking bench for ex_mem_execute_stage; expectations follow the EX_FORWARD_EN build setting.

module tb_ex_mem_execute_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] pc_plus_4_in;
    logic [31:0] reg_file_out_1_in;
    logic [31:0] reg_file_out_2_in;
    logic [31:0] sign_extended_in;
    logic [4:0]  reg_rs_address_in;
    logic [4:0]  reg_rt_address_in;
    logic [4:0]  reg_rd_address_in;
    logic [1:0]  register_destination_in;
    logic [1:0]  alu_op_in;
    logic        memory_read_in;
    logic        memory_write_in;
    logic        memory_to_register_in;
    logic        alu_source_in;
    logic        reg_write_in;
    logic        memory_write_source_in;
    logic        memory_read_source_in;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg;
    logic [31:0] mem_wb_write_data;
    logic        ex_stall;
    logic [31:0] alu_result_out;
    logic [31:0] write_data_out;
    logic [4:0]  write_reg_out;
    logic        memory_read_out;
    logic        memory_write_out;
    logic        memory_to_register_out;
    logic        reg_write_out;
    logic        memory_write_source_out;
    logic        memory_read_source_out;

    int checks;
    int failures;
    int stall_cycles;
    logic bubble_bad;

`ifdef EX_FORWARD_EN
    localparam logic [31:0] SUB_EXPECT = 32'd10;
`else
    localparam logic [31:0] SUB_EXPECT = 32'd98;
`endif

    ex_mem_execute_stage dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .flush                   (flush),
        .pc_plus_4_in            (pc_plus_4_in),
        .reg_file_out_1_in       (reg_file_out_1_in),
        .reg_file_out_2_in       (reg_file_out_2_in),
        .sign_extended_in        (sign_extended_in),
        .reg_rs_address_in       (reg_rs_address_in),
        .reg_rt_address_in       (reg_rt_address_in),
        .reg_rd_address_in       (reg_rd_address_in),
        .register_destination_in (register_destination_in),
        .alu_op_in               (alu_op_in),
        .memory_read_in          (memory_read_in),
        .memory_write_in         (memory_write_in),
        .memory_to_register_in   (memory_to_register_in),
        .alu_source_in           (alu_source_in),
        .reg_write_in            (reg_write_in),
        .memory_write_source_in  (memory_write_source_in),
        .memory_read_source_in   (memory_read_source_in),
        .mem_wb_reg_write        (mem_wb_reg_write),
        .mem_wb_write_reg        (mem_wb_write_reg),
        .mem_wb_write_data       (mem_wb_write_data),
        .ex_stall                (ex_stall),
        .alu_result_out          (alu_result_out),
        .write_data_out          (write_data_out),
        .write_reg_out           (write_reg_out),
        .memory_read_out         (memory_read_out),
        .memory_write_out        (memory_write_out),
        .memory_to_register_out  (memory_to_register_out),
        .reg_write_out           (reg_write_out),
        .memory_write_source_out (memory_write_source_out),
        .memory_read_source_out  (memory_read_source_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] dst, input logic alu_src,
                                 input logic [31:0] a_val, input logic [31:0] b_val,
                                 input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic wr);
        alu_op_in               = op;
        register_destination_in = dst;
        alu_source_in           = alu_src;
        reg_file_out_1_in       = a_val;
        reg_file_out_2_in       = b_val;
        sign_extended_in        = imm;
        reg_rs_address_in       = rs;
        reg_rt_address_in       = rt;
        reg_rd_address_in       = rd;
        reg_write_in            = wr;
        pc_plus_4_in            = 32'h0000_0100;
        memory_read_in          = 1'b0;
        memory_write_in         = 1'b0;
        memory_to_register_in   = 1'b0;
        memory_write_source_in  = 1'b0;
        memory_read_source_in   = 1'b0;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        flush             = 1'b0;
        mem_wb_reg_write  = 1'b0;
        mem_wb_write_reg  = 5'd0;
        mem_wb_write_data = 32'd0;
        applyStimulus(2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state, including stall suppression with a MULT presented
        checkOutput("reset_alu_result", alu_result_out, 32'd0);
        checkOutput("reset_reg_write", {31'd0, reg_write_out}, 32'd0);
        checkOutput("reset_write_reg", {27'd0, write_reg_out}, 32'd0);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd5, 32'd6, 32'h18, 5'd10, 5'd11, 5'd9, 1'b1);
        checkOutput("reset_stall", {31'd0, ex_stall}, 32'd0);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // add r3 = 5 + 7
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd5, 32'd7, 32'h20, 5'd5, 5'd7, 5'd3, 1'b1);
        tick();
        checkOutput("add_result", alu_result_out, 32'd12);
        checkOutput("add_write_reg", {27'd0, write_reg_out}, 32'd3);
        checkOutput("add_reg_write", {31'd0, reg_write_out}, 32'd1);

        // sub r4 = r3 - r1 with a stale register-file r3 of 100
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd100, 32'd2, 32'h22, 5'd3, 5'd1, 5'd4, 1'b1);
        tick();
        checkOutput("fwd_exmem_sub", alu_result_out, SUB_EXPECT);
        checkOutput("sub_store_data", write_data_out, 32'd2);

        // Same again with MEM/WB also targeting r3
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd5, 32'd7, 32'h20, 5'd5, 5'd7, 5'd3, 1'b1);
        tick();
        mem_wb_reg_write  = 1'b1;
        mem_wb_write_reg  = 5'd3;
        mem_wb_write_data = 32'd99;
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd100, 32'd2, 32'h22, 5'd3, 5'd1, 5'd4, 1'b1);
        tick();
        checkOutput("fwd_priority_sub", alu_result_out, SUB_EXPECT);

        // Writes to r0 are never forwarded
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd5, 32'd7, 32'h20, 5'd5, 5'd7, 5'd0, 1'b1);
        tick();
        checkOutput("r0_write_reg", {27'd0, write_reg_out}, 32'd0);
        mem_wb_write_reg = 5'd0;
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd2, 32'h22, 5'd0, 5'd1, 5'd4, 1'b1);
        tick();
        checkOutput("r0_no_forward", alu_result_out, 32'hFFFF_FFFE);
        mem_wb_reg_write = 1'b0;

        // ori and addi-style immediate forms
        applyStimulus(2'b11, 2'b00, 1'b1, 32'h0000_00F0, 32'd0, 32'hFFFF_000F, 5'd6, 5'd7, 5'd0, 1'b1);
        tick();
        checkOutput("ori_result", alu_result_out, 32'h0000_00FF);
        checkOutput("ori_write_reg", {27'd0, write_reg_out}, 32'd7);
        applyStimulus(2'b00, 2'b00, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd6, 5'd8, 5'd0, 1'b1);
        tick();
        checkOutput("addi_result", alu_result_out, 32'd9);

        // slt, then slt flushed, then shifts
        applyStimulus(2'b10, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd12, 5'd13, 5'd14, 1'b1);
        tick();
        checkOutput("slt_result", alu_result_out, 32'd1);
        flush = 1'b1;
        tick();
        checkOutput("slt_flush_reg_write", {31'd0, reg_write_out}, 32'd0);
        checkOutput("slt_flush_result", alu_result_out, 32'd0);
        flush = 1'b0;
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd1, 32'h0000_07C0, 5'd12, 5'd13, 5'd14, 1'b1);
        tick();
        checkOutput("sll_result", alu_result_out, 32'h8000_0000);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'h8000_0000, 32'h0000_0102, 5'd12, 5'd13, 5'd14, 1'b1);
        tick();
        checkOutput("srl_result", alu_result_out, 32'h0800_0000);

        // jal
        applyStimulus(2'b00, 2'b10, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        pc_plus_4_in = 32'h0040_0008;
        tick();
        checkOutput("jal_write_reg", {27'd0, write_reg_out}, 32'd31);
        checkOutput("jal_result", alu_result_out, 32'h0040_0008);
        checkOutput("jal_reg_write", {31'd0, reg_write_out}, 32'd1);

        // MULT flushed at counter 10 leaves HI/LO at their reset values
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd5, 32'd6, 32'h18, 5'd10, 5'd11, 5'd9, 1'b1);
        checkOutput("mult_stall_entry", {31'd0, ex_stall}, 32'd1);
        tick();
        checkOutput("mult_busy_bubble", {31'd0, reg_write_out}, 32'd0);
        repeat (10) tick();
        checkOutput("mult_stall_c10", {31'd0, ex_stall}, 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("mult_flush_stall_drop", {31'd0, ex_stall}, 32'd0);
        tick();
        flush = 1'b0;
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 5'd8, 1'b1);
        tick();
        checkOutput("mfhi_after_flush", alu_result_out, 32'd0);
        checkOutput("mfhi_after_flush_we", {31'd0, reg_write_out}, 32'd1);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        checkOutput("mflo_after_flush", alu_result_out, 32'd0);

        // MULT -3 * 7: 33 stall cycles, bubbles throughout, product in HI/LO
        applyStimulus(2'b10, 2'b01, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h18, 5'd10, 5'd11, 5'd9, 1'b1);
        stall_cycles = 0;
        bubble_bad   = 1'b0;
        while (ex_stall === 1'b1 && stall_cycles < 100) begin
            stall_cycles++;
            tick();
            if (reg_write_out !== 1'b0) bubble_bad = 1'b1;
        end
        checkOutput("mult_stall_cycles", stall_cycles, 32'd33);
        checkOutput("mult_stall_bubbles", {31'd0, bubble_bad}, 32'd0);
        tick();
        checkOutput("mult_retire_bubble", {31'd0, reg_write_out}, 32'd0);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 5'd8, 1'b1);
        tick();
        checkOutput("mfhi_product", alu_result_out, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        checkOutput("mflo_product", alu_result_out, 32'hFFFF_FFEB);

        // Reset mid-MULT aborts and clears HI/LO
        applyStimulus(2'b10, 2'b01, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h18, 5'd10, 5'd11, 5'd9, 1'b1);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_mult_stall", {31'd0, ex_stall}, 32'd0);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 5'd8, 1'b1);
        rst_n = 1'b1;
        tick();
        checkOutput("mfhi_after_reset", alu_result_out, 32'd0);
        checkOutput("mfhi_after_reset_we", {31'd0, reg_write_out}, 32'd1);
        checkOutput("mfhi_after_reset_stall", {31'd0, ex_stall}, 32'd0);

        // Asynchronous reset clears live outputs immediately
        applyStimulus(2'b00, 2'b10, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        pc_plus_4_in = 32'h0040_0010;
        tick();
        checkOutput("pre_reset_result", alu_result_out, 32'h0040_0010);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_result", alu_result_out, 32'd0);
        checkOutput("async_reset_write_reg", {27'd0, write_reg_out}, 32'd0);
        checkOutput("async_reset_reg_write", {31'd0, reg_write_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
